// File: rtl/rc_seq_pkg.sv
// rtl/rc_seq_pkg.sv - shared types and defaults for the rate-control block sequencer
package rc_seq_pkg;

    localparam int BLK_PIX_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RUN    = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } rc_seq_state_e;

endpackage

// File: rtl/rc_seq_counters.sv
// rtl/rc_seq_counters.sv - per-slice pixel/block counters with saturating remaining count
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   init_en                   load: clear coded counters, remaining <= cfg_slice_pixels, latch delay
//   upd_en                    account one block: pixels += BLK_PIX, blocks += 1, remaining saturates at 0
//   cfg_slice_pixels          slice size, sampled when init_en
//   cfg_init_tx_delay         initial transmission delay in blocks, sampled when init_en
//   num_pixels_coded          pixels coded so far
//   num_blocks_coded          blocks coded so far
//   slice_pixels_remaining    pixels not yet coded
//   init_phase                (pixels + BLK_PIX) <= delay * BLK_PIX
//   last_blk                  0 < remaining <= BLK_PIX
module rc_seq_counters #(
    parameter int BLK_PIX = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             init_en,
    input  logic             upd_en,
    input  logic [CNT_W-1:0] cfg_slice_pixels,
    input  logic [7:0]       cfg_init_tx_delay,
    output logic [CNT_W-1:0] num_pixels_coded,
    output logic [CNT_W-1:0] num_blocks_coded,
    output logic [CNT_W-1:0] slice_pixels_remaining,
    output logic             init_phase,
    output logic             last_blk
);

    // The delay product needs 8 extra bits so 255 * BLK_PIX never truncates.
    localparam int              PW  = CNT_W + 8;
    localparam logic [CNT_W-1:0] BLK = CNT_W'(BLK_PIX);

    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       dly_q, dly_d;
    logic [PW-1:0]    phase_lhs;
    logic [PW-1:0]    phase_rhs;

    always_comb begin
        pix_d = pix_q;
        blk_d = blk_q;
        rem_d = rem_q;
        dly_d = dly_q;
        if (init_en) begin
            pix_d = '0;
            blk_d = '0;
            rem_d = cfg_slice_pixels;
            dly_d = cfg_init_tx_delay;
        end else if (upd_en) begin
            pix_d = pix_q + BLK;
            blk_d = blk_q + CNT_W'(1);
            // A partial final block consumes whatever is left; never wrap below zero.
            rem_d = (rem_q > BLK) ? (rem_q - BLK) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_q <= '0;
            blk_q <= '0;
            rem_q <= '0;
            dly_q <= '0;
        end else begin
            pix_q <= pix_d;
            blk_q <= blk_d;
            rem_q <= rem_d;
            dly_q <= dly_d;
        end
    end

    always_comb begin
        phase_lhs = PW'(pix_q) + PW'(BLK_PIX);
        phase_rhs = PW'(dly_q) * PW'(BLK_PIX);
    end

    assign init_phase             = (phase_lhs <= phase_rhs);
    assign last_blk               = (rem_q != '0) && (rem_q <= BLK);
    assign num_pixels_coded       = pix_q;
    assign num_blocks_coded       = blk_q;
    assign slice_pixels_remaining = rem_q;

endmodule

// File: rtl/rc_block_sequencer.sv
// rtl/rc_block_sequencer.sv - slice/block sequencer driving rate-control offset updates
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   slice_start               pulse: begin a new slice (only honoured in IDLE)
//   cfg_slice_pixels          pixels in the slice, sampled in INIT
//   cfg_init_tx_delay         initial transmission delay in blocks, sampled in INIT
//   blk_valid / blk_ready     decoder block-report handshake
//   upd_stb                   one-cycle strobe to RC offset update, counters hold pre-block values
//   num_pixels_coded, num_blocks_coded, slice_pixels_remaining   slice progress
//   init_phase, last_blk      combinational flags derived from the counters
//   slice_done                one-cycle pulse at end of slice
//   busy                      high outside IDLE
//   err_overlap               sticky: slice_start seen while not IDLE
module rc_block_sequencer
    import rc_seq_pkg::*;
#(
    parameter int BLK_PIX = BLK_PIX_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             slice_start,
    input  logic [CNT_W-1:0] cfg_slice_pixels,
    input  logic [7:0]       cfg_init_tx_delay,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             upd_stb,
    output logic [CNT_W-1:0] num_pixels_coded,
    output logic [CNT_W-1:0] num_blocks_coded,
    output logic [CNT_W-1:0] slice_pixels_remaining,
    output logic             init_phase,
    output logic             last_blk,
    output logic             slice_done,
    output logic             busy,
    output logic             err_overlap
);

    rc_seq_state_e state_q, state_d;
    logic          blk_ready_q, blk_ready_d;
    logic          upd_stb_q, upd_stb_d;
    logic          slice_done_q, slice_done_d;
    logic          busy_q, busy_d;
    logic          err_overlap_q, err_overlap_d;

    always_comb begin
        state_d       = state_q;
        err_overlap_d = err_overlap_q;
        case (state_q)
            IDLE:    if (slice_start) state_d = INIT;
            INIT:    state_d = (cfg_slice_pixels == '0) ? DONE : RUN;
            RUN:     if (blk_valid && blk_ready_q) state_d = UPDATE;
            UPDATE:  state_d = last_blk ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (slice_start && (state_q != IDLE)) begin
            err_overlap_d = 1'b1;
        end
        // Outputs are registered and decoded from the next state so they line up with it.
        blk_ready_d  = (state_d == RUN);
        upd_stb_d    = (state_d == UPDATE);
        slice_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            blk_ready_q   <= 1'b0;
            upd_stb_q     <= 1'b0;
            slice_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_ready_q   <= blk_ready_d;
            upd_stb_q     <= upd_stb_d;
            slice_done_q  <= slice_done_d;
            busy_q        <= busy_d;
            err_overlap_q <= err_overlap_d;
        end
    end

    rc_seq_counters #(
        .BLK_PIX (BLK_PIX),
        .CNT_W   (CNT_W)
    ) u_counters (
        .clk                    (clk),
        .rstn                   (rstn),
        .init_en                (state_q == INIT),
        .upd_en                 (state_q == UPDATE),
        .cfg_slice_pixels       (cfg_slice_pixels),
        .cfg_init_tx_delay      (cfg_init_tx_delay),
        .num_pixels_coded       (num_pixels_coded),
        .num_blocks_coded       (num_blocks_coded),
        .slice_pixels_remaining (slice_pixels_remaining),
        .init_phase             (init_phase),
        .last_blk               (last_blk)
    );

    assign blk_ready   = blk_ready_q;
    assign upd_stb     = upd_stb_q;
    assign slice_done  = slice_done_q;
    assign busy        = busy_q;
    assign err_overlap = err_overlap_q;

endmodule

// File: tb/tb_rc_block_sequencer.sv
// tb/tb_rc_block_sequencer.sv - self-checking bench for rc_block_sequencer
module tb_rc_block_sequencer;

    logic        clk;
    logic        rstn;
    logic        slice_start;
    logic [15:0] cfg_slice_pixels;
    logic [7:0]  cfg_init_tx_delay;
    logic        blk_valid;
    logic        blk_ready;
    logic        upd_stb;
    logic [15:0] num_pixels_coded;
    logic [15:0] num_blocks_coded;
    logic [15:0] slice_pixels_remaining;
    logic        init_phase;
    logic        last_blk;
    logic        slice_done;
    logic        busy;
    logic        err_overlap;

    int n_pass  = 0;
    int n_total = 0;

    rc_block_sequencer dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .slice_start            (slice_start),
        .cfg_slice_pixels       (cfg_slice_pixels),
        .cfg_init_tx_delay      (cfg_init_tx_delay),
        .blk_valid              (blk_valid),
        .blk_ready              (blk_ready),
        .upd_stb                (upd_stb),
        .num_pixels_coded       (num_pixels_coded),
        .num_blocks_coded       (num_blocks_coded),
        .slice_pixels_remaining (slice_pixels_remaining),
        .init_phase             (init_phase),
        .last_blk               (last_blk),
        .slice_done             (slice_done),
        .busy                   (busy),
        .err_overlap            (err_overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pix;
        int dly;
        int exp_upd;
        int exp_pix;
        int exp_blk;
        int exp_init;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_upd"},   32'(upd_stb), 0);
        check({tag, "_ready"}, 32'(blk_ready), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(slice_done), 0);
        check({tag, "_err"},   32'(err_overlap), 0);
        check({tag, "_pix"},   32'(num_pixels_coded), 0);
        check({tag, "_blk"},   32'(num_blocks_coded), 0);
        check({tag, "_rem"},   32'(slice_pixels_remaining), 0);
        check({tag, "_phase"}, 32'(init_phase), 0);
        check({tag, "_last"},  32'(last_blk), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        slice_start = 1'b0;
        blk_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Runs one slice; the model predicts each block k from the slice size alone:
    // pre-block pixels k*BLK, remaining pix-k*BLK, init_phase iff k+1 <= delay, last iff k == nblk-1.
    task automatic run_slice(input int pix, input int dly, input int pct,
                             output int n_upd, output int n_init);
        int  nblk;
        int  last_upd;
        int  k;
        bit  done;
        bit  prev_hs;
        nblk     = (pix + 15) / 16;
        n_upd    = 0;
        n_init   = 0;
        done     = 1'b0;
        prev_hs  = 1'b0;
        last_upd = -10;
        @(negedge clk);
        cfg_slice_pixels  = 16'(pix);
        cfg_init_tx_delay = 8'(dly);
        slice_start       = 1'b1;
        blk_valid         = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            slice_start = 1'b0;
            check("upd_latency", 32'(upd_stb), 32'(prev_hs));
            if (cyc == 0) begin
                check("init_busy", 32'(busy), 1);
                check("init_ready", 32'(blk_ready), 0);
            end
            if (cyc == 1) begin
                cfg_slice_pixels  = 16'($urandom);
                cfg_init_tx_delay = 8'($urandom);
                check("start_to_ready", 32'(blk_ready), (pix != 0) ? 1 : 0);
                check("zero_done", 32'(slice_done), (pix == 0) ? 1 : 0);
            end
            if (upd_stb) begin
                k = n_upd;
                check("upd_pix", 32'(num_pixels_coded), k * 16);
                check("upd_blk", 32'(num_blocks_coded), k);
                check("upd_rem", 32'(slice_pixels_remaining), (pix > k * 16) ? pix - k * 16 : 0);
                check("upd_phase", 32'(init_phase), (k + 1 <= dly) ? 1 : 0);
                check("upd_last", 32'(last_blk), (k == nblk - 1) ? 1 : 0);
                check("upd_ready_low", 32'(blk_ready), 0);
                if (pct == 100 && n_upd > 0) check("upd_spacing", cyc - last_upd, 2);
                if (init_phase) n_init++;
                last_upd = cyc;
                n_upd++;
            end
            if (slice_done) begin
                check("final_pix", 32'(num_pixels_coded), nblk * 16);
                check("final_blk", 32'(num_blocks_coded), nblk);
                check("final_rem", 32'(slice_pixels_remaining), 0);
                check("final_phase", 32'(init_phase), (nblk + 1 <= dly) ? 1 : 0);
                check("final_upd_count", n_upd, nblk);
                done = 1'b1;
            end
            blk_valid = ($urandom_range(99) < pct) && !done;
            prev_hs   = blk_valid && blk_ready;
        end
        check("slice_timeout", 32'(done), 1);
        @(negedge clk);
        blk_valid = 1'b0;
        check("done_one_cycle", 32'(slice_done), 0);
        check("back_to_idle", 32'(busy), 0);
    endtask

    initial begin
        int  n_upd;
        int  n_init;
        int  cnt;
        bit  seen;

        rstn              = 1'b0;
        slice_start       = 1'b0;
        cfg_slice_pixels  = '0;
        cfg_init_tx_delay = '0;
        blk_valid         = 1'b0;

        vecs[0] = '{pix: 64, dly: 2,   exp_upd: 4, exp_pix: 64, exp_blk: 4, exp_init: 2};
        vecs[1] = '{pix: 40, dly: 0,   exp_upd: 3, exp_pix: 48, exp_blk: 3, exp_init: 0};
        vecs[2] = '{pix: 0,  dly: 5,   exp_upd: 0, exp_pix: 0,  exp_blk: 0, exp_init: 0};
        vecs[3] = '{pix: 16, dly: 1,   exp_upd: 1, exp_pix: 16, exp_blk: 1, exp_init: 1};
        vecs[4] = '{pix: 17, dly: 3,   exp_upd: 2, exp_pix: 32, exp_blk: 2, exp_init: 2};
        vecs[5] = '{pix: 1,  dly: 0,   exp_upd: 1, exp_pix: 16, exp_blk: 1, exp_init: 0};
        vecs[6] = '{pix: 48, dly: 255, exp_upd: 3, exp_pix: 48, exp_blk: 3, exp_init: 3};

        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Table vectors, blk_valid held high.
        foreach (vecs[i]) begin
            run_slice(vecs[i].pix, vecs[i].dly, 100, n_upd, n_init);
            check("vec_upd", n_upd, vecs[i].exp_upd);
            check("vec_init_high", n_init, vecs[i].exp_init);
            check("vec_pix", 32'(num_pixels_coded), vecs[i].exp_pix);
            check("vec_blk", 32'(num_blocks_coded), vecs[i].exp_blk);
        end
        check("vec_no_overlap", 32'(err_overlap), 0);

        // Randomised slices with sporadic blk_valid.
        for (int r = 0; r < 20; r++) begin
            run_slice(int'($urandom_range(150)), int'($urandom_range(12)),
                      int'($urandom_range(100, 20)), n_upd, n_init);
        end

        // slice_start during RUN: flagged, ignored, counters untouched.
        do_reset();
        @(negedge clk);
        cfg_slice_pixels  = 16'd64;
        cfg_init_tx_delay = 8'd2;
        slice_start       = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        @(negedge clk);
        check("ovl_in_run", 32'(blk_ready), 1);
        check("ovl_err_before", 32'(err_overlap), 0);
        cfg_slice_pixels = 16'd8;
        slice_start      = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        check("ovl_err_set", 32'(err_overlap), 1);
        check("ovl_rem", 32'(slice_pixels_remaining), 64);
        check("ovl_pix", 32'(num_pixels_coded), 0);
        check("ovl_still_run", 32'(blk_ready), 1);
        blk_valid = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (upd_stb) cnt++;
            if (slice_done) seen = 1'b1;
        end
        blk_valid = 1'b0;
        check("ovl_slice_done", 32'(seen), 1);
        check("ovl_upd_count", cnt, 4);
        check("ovl_err_sticky", 32'(err_overlap), 1);

        // slice_start during DONE: flagged, does not restart.
        do_reset();
        check("err_cleared_by_reset", 32'(err_overlap), 0);
        @(negedge clk);
        cfg_slice_pixels = 16'd0;
        slice_start      = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        @(negedge clk);
        check("done_ovl_in_done", 32'(slice_done), 1);
        slice_start = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        check("done_ovl_err", 32'(err_overlap), 1);
        check("done_ovl_idle", 32'(busy), 0);
        @(negedge clk);
        check("done_ovl_no_restart", 32'(busy), 0);

        // Reset asserted while in UPDATE aborts the slice without slice_done.
        do_reset();
        @(negedge clk);
        cfg_slice_pixels  = 16'd64;
        cfg_init_tx_delay = 8'd3;
        slice_start       = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        blk_valid   = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (upd_stb) seen = 1'b1;
        end
        check("rst_reached_update", 32'(seen), 1);
        rstn = 1'b0;
        #1;
        check_all_zero("rst_upd");
        @(negedge clk);
        check_all_zero("rst_upd_next");
        rstn      = 1'b1;
        blk_valid = 1'b0;
        @(negedge clk);
        check("rst_idle_busy", 32'(busy), 0);
        check("rst_no_done", 32'(slice_done), 0);
        check("rst_no_ready", 32'(blk_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rc_block_sequencer.md
RC_BLOCK_SEQUENCER -- requirements
Module: rc_block_sequencer

Interface
REQ-001 SHALL have parameter BLK_PIX, default 16, pixels per block.
REQ-002 SHALL have parameter CNT_W, default 16, width of all pixel/block counters.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port slice_start  input  1  one-cycle pulse, begin new slice.
REQ-006 SHALL have port cfg_slice_pixels  input  CNT_W  total pixels in slice; sampled in INIT only.
REQ-007 SHALL have port cfg_init_tx_delay  input  8  initial transmission delay in blocks; sampled in INIT only.
REQ-008 SHALL have port blk_valid  input  1  decoder reports one block decoded.
REQ-009 SHALL have port blk_ready  output  1  sequencer accepts a block report.
REQ-010 SHALL have port upd_stb  output  1  one-cycle strobe to RC offset update logic.
REQ-011 SHALL have port num_pixels_coded  output  CNT_W  pixels coded so far in slice.
REQ-012 SHALL have port num_blocks_coded  output  CNT_W  blocks coded so far in slice.
REQ-013 SHALL have port slice_pixels_remaining  output  CNT_W  pixels not yet coded.
REQ-014 SHALL have port init_phase  output  1  high while (num_pixels_coded+BLK_PIX) <= cfg_init_tx_delay*BLK_PIX.
REQ-015 SHALL have port last_blk  output  1  high when 0 < slice_pixels_remaining <= BLK_PIX.
REQ-016 SHALL have ports slice_done (1-cycle pulse), busy, err_overlap (sticky), all output 1.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, RUN, UPDATE, DONE.
REQ-018 IDLE: busy=0, blk_ready=0; slice_start -> INIT next cycle.
REQ-019 INIT (1 cycle): latch cfg_*; num_pixels_coded=0, num_blocks_coded=0, slice_pixels_remaining=cfg_slice_pixels; -> RUN, or -> DONE if cfg_slice_pixels==0 (no upd_stb).
REQ-020 RUN: blk_ready=1; blk_valid&blk_ready -> UPDATE; blk_valid ignored in all other states.
REQ-021 UPDATE (1 cycle): upd_stb=1 with counters still holding pre-block values; at cycle end pixels+=BLK_PIX, blocks+=1, remaining-=min(remaining,BLK_PIX).
REQ-022 UPDATE exit: -> DONE if last_blk was high during UPDATE, else -> RUN.
REQ-023 DONE (1 cycle): slice_done=1; counters hold final values; -> IDLE.
REQ-024 Latency: slice_start at t -> blk_ready at t+2; handshake at n -> upd_stb at n+1, updated counters and blk_ready at n+2; max 1 block per 2 cycles.
REQ-025 init_phase and last_blk SHALL be combinational from registered counters and latched config; product computed at CNT_W+8 bits, no truncation.
REQ-026 Remaining not a multiple of BLK_PIX: final partial block treated as last; remaining saturates at 0, never wraps.
REQ-027 slice_start while not IDLE: ignored, err_overlap set; slice_start in DONE same rule.
REQ-028 busy=1 in every state except IDLE.

Reset
REQ-029 On rstn low: state=IDLE, all counters 0, upd_stb/slice_done/blk_ready/busy/err_overlap 0, latched config 0.
REQ-030 Reset mid-slice SHALL abort immediately with no slice_done; err_overlap cleared only by reset.

Structure
REQ-031 Package rc_seq_pkg SHALL hold the state enum, BLK_PIX and CNT_W defaults.
REQ-032 Counters and remaining-pixel saturation SHALL live in one sub-module rc_seq_counters; FSM in top.

Verification
REQ-033 cfg_slice_pixels=64, 4 blocks -> 4 upd_stb, final pixels=64, blocks=4, remaining=0, one slice_done.
REQ-034 cfg_init_tx_delay=2, 64 pixels -> init_phase high for blocks_coded 0,1; low from 2.
REQ-035 cfg_slice_pixels=40 -> 3 upd_stb, last_blk during 3rd, remaining 40->24->8->0.
REQ-036 cfg_slice_pixels=0 -> INIT->DONE, slice_done at t+2, zero upd_stb.
REQ-037 slice_start during RUN -> err_overlap=1, counters unaffected; blk_valid held high continuously -> upd_stb every 2nd cycle.
REQ-038 rstn low during UPDATE -> next cycle all outputs 0, state IDLE, no slice_done.
